// File: rtl/cmult_pkg.sv
// Shared Q15 complex types and the saturating rescale used by the multiplier core.
package cmult_pkg;

    localparam int Q15_W  = 16;
    localparam int PROD_W = 32;

    localparam logic signed [PROD_W:0] Q15_MAX = 33'sd32767;
    localparam logic signed [PROD_W:0] Q15_MIN = -33'sd32768;

    typedef struct packed {
        logic signed [Q15_W-1:0] re;
        logic signed [Q15_W-1:0] im;
    } cplx_q15_t;

    // Q30 sum -> Q15: arithmetic shift (floor) then clamp to the 16-bit range.
    function automatic logic signed [Q15_W-1:0] sat_q15(input logic signed [PROD_W:0] v);
        logic signed [PROD_W:0] s;
        s = v >>> 15;
        if (s > Q15_MAX)      return 16'sh7fff;
        else if (s < Q15_MIN) return 16'sh8000;
        else                  return s[Q15_W-1:0];
    endfunction

endpackage

// File: rtl/cmult_sat_core.sv
// Combinational saturating Q15 complex multiply y = x0 * x1.
// Define CMULT_ARB_GAUSS_EN for the 3-multiplier form; results are identical either way.
module cmult_sat_core
    import cmult_pkg::*;
(
    input  cplx_q15_t x0,
    input  cplx_q15_t x1,
    output cplx_q15_t y
);

    logic signed [PROD_W:0] re_w;
    logic signed [PROD_W:0] im_w;

`ifdef CMULT_ARB_GAUSS_EN
    logic signed [Q15_W:0]  sum_a;
    logic signed [Q15_W:0]  sum_b;
    logic signed [Q15_W:0]  sum_c;
    logic signed [PROD_W:0] k1;
    logic signed [PROD_W:0] k2;
    logic signed [PROD_W:0] k3;

    // k2 uses x0_re*(x1_im-x1_re) so that k1+k2 reduces exactly to ri+ir.
    // The 33-bit sums may wrap in between, but the final values fit, so they are exact.
    assign sum_a = {x0.re[Q15_W-1], x0.re} + {x0.im[Q15_W-1], x0.im};
    assign sum_b = {x1.im[Q15_W-1], x1.im} - {x1.re[Q15_W-1], x1.re};
    assign sum_c = {x1.re[Q15_W-1], x1.re} + {x1.im[Q15_W-1], x1.im};
    assign k1    = x1.re * sum_a;
    assign k2    = x0.re * sum_b;
    assign k3    = x0.im * sum_c;
    assign re_w  = k1 - k3;
    assign im_w  = k1 + k2;
`else
    logic signed [PROD_W-1:0] rr;
    logic signed [PROD_W-1:0] ii;
    logic signed [PROD_W-1:0] ri;
    logic signed [PROD_W-1:0] ir;

    assign rr   = x0.re * x1.re;
    assign ii   = x0.im * x1.im;
    assign ri   = x0.re * x1.im;
    assign ir   = x0.im * x1.re;
    assign re_w = rr - ii;
    assign im_w = ri + ir;
`endif

    always_comb begin
        y.re = sat_q15(re_w);
        y.im = sat_q15(im_w);
    end

endmodule

// File: rtl/cmult_share_arb.sv
// Round-robin arbiter sharing one saturating Q15 complex multiplier through a
// 2-stage pipe. The CMULT_ARB_GAUSS_EN build option is handled inside cmult_sat_core.
module cmult_share_arb
    import cmult_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [16*NUM_REQ-1:0]    req_x0_re,
    input  logic [16*NUM_REQ-1:0]    req_x0_im,
    input  logic [16*NUM_REQ-1:0]    req_x1_re,
    input  logic [16*NUM_REQ-1:0]    req_x1_im,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ID_W-1:0]          res_id,
    output logic signed [Q15_W-1:0]  res_re,
    output logic signed [Q15_W-1:0]  res_im
);

    logic [ID_W-1:0]    last_grant;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               found;
    logic [ID_W-1:0]    idx;
    logic               advance;
    logic               xfer;

    cplx_q15_t          op0, op1, prod;
    logic               s1_valid, s2_valid;
    logic [ID_W-1:0]    s1_id, s2_id;
    cplx_q15_t          s1_x0, s1_x1, s2_data;

    // Search starts one past the last transfer, so the last winner is lowest priority.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                found      = 1'b1;
            end
        end
    end

    assign advance   = ~s2_valid | res_ready;
    assign req_ready = grant & {NUM_REQ{advance}};
    assign xfer      = |req_ready;

    always_comb begin
        op0.re = req_x0_re[16*grant_id +: 16];
        op0.im = req_x0_im[16*grant_id +: 16];
        op1.re = req_x1_re[16*grant_id +: 16];
        op1.im = req_x1_im[16*grant_id +: 16];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= ID_W'(NUM_REQ - 1);
            s1_valid   <= 1'b0;
            s1_id      <= '0;
            s2_valid   <= 1'b0;
            s2_id      <= '0;
            s2_data    <= '0;
        end else begin
            if (xfer) last_grant <= grant_id;
            if (advance) begin
                s1_valid <= xfer;
                s2_valid <= s1_valid;
                if (xfer) s1_id <= grant_id;
                if (s1_valid) begin
                    s2_id   <= s1_id;
                    s2_data <= prod;
                end
            end
        end
    end

    // NOTE: stage-1 operands are qualified by s1_valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (xfer) begin
            s1_x0 <= op0;
            s1_x1 <= op1;
        end
    end

    cmult_sat_core u_core (
        .x0 (s1_x0),
        .x1 (s1_x1),
        .y  (prod)
    );

    assign res_valid = s2_valid;
    assign res_id    = s2_id;
    assign res_re    = s2_data.re;
    assign res_im    = s2_data.im;

endmodule

// File: tb/tb_cmult_share_arb.sv
// Directed bench for cmult_share_arb: vector table for arithmetic plus
// hand-written sequences for rotation, stall, partial requesters and mid-run reset.
module tb_cmult_share_arb;

    localparam int NR = 4;
    localparam int IW = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_ready;
    logic [16*NR-1:0]     x0_re, x0_im, x1_re, x1_im;
    logic                 res_valid;
    logic                 res_ready;
    logic [IW-1:0]        res_id;
    logic signed [15:0]   res_re, res_im;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int id;
        int a_re, a_im, b_re, b_im;
        int e_re, e_im;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    cmult_share_arb #(.NUM_REQ(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x0_re (x0_re),
        .req_x0_im (x0_im),
        .req_x1_re (x1_re),
        .req_x1_im (x1_im),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_re    (res_re),
        .res_im    (res_im)
    );

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_op(input int i, input int a_re, input int a_im, input int b_re, input int b_im);
        x0_re[16*i +: 16] = 16'(a_re);
        x0_im[16*i +: 16] = 16'(a_im);
        x1_re[16*i +: 16] = 16'(b_re);
        x1_im[16*i +: 16] = 16'(b_im);
    endtask

    // Requester i computes (1000*(i+1)) * 0.5 -> re = 500*(i+1), im = 0.
    task automatic load_rr_ops();
        for (int i = 0; i < NR; i++) set_op(i, 1000 * (i + 1), 0, 16384, 0);
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst_n     = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic check_res(input string name, input int exp_id);
        if (exp_id < 0) begin
            check({name, "_valid"}, 32'(res_valid), 0);
        end else begin
            check({name, "_valid"}, 32'(res_valid), 1);
            check({name, "_id"},    32'(res_id),    exp_id);
            check({name, "_re"},    res_re,         500 * (exp_id + 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    initial begin
        int st_rdy[13] = '{0, 1, -1, -1, -1, -1, -1, 2, 3, 0, -1, -1, -1};
        int st_res[13] = '{-1, -1, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, -1};
        int pr_g[9]    = '{1, 3, 1, 3, 1, 1, 1, -1, -1};
        int g;

        vecs[0] = '{2,  16384,      0,  16384,      0,   8192,      0};
        vecs[1] = '{0, -32768,      0, -32768,      0,  32767,      0};
        vecs[2] = '{1,  16384,  16384,  16384, -16384,  16384,      0};
        vecs[3] = '{3,      0, -32768,      0, -32768, -32768,      0};
        vecs[4] = '{0, -32768, -32768, -32768,  32767,  32767,      1};
        vecs[5] = '{1,      1,      0,     -1,      0,     -1,      0};
        vecs[6] = '{2,      1,      0,      1,      0,      0,      0};
        vecs[7] = '{3,    100,   -200,    300,    400,      3,     -1};
        vecs[8] = '{0,  32767,  32767,  32767,  32767,      0,  32767};
        vecs[9] = '{2, -32768, -32768,  32767,  32767,      0, -32768};

        rst_n     = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        x0_re = '0; x0_im = '0; x1_re = '0; x1_im = '0;
        #12;
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_id",    32'(res_id),    0);
        check("rst_res_re",    res_re,         0);
        check("rst_res_im",    res_im,         0);
        check("rst_req_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Arithmetic table: single transfer, result exactly two edges later.
        foreach (vecs[v]) begin
            @(posedge clk); #1;
            set_op(vecs[v].id, vecs[v].a_re, vecs[v].a_im, vecs[v].b_re, vecs[v].b_im);
            req_valid = NR'(1 << vecs[v].id);
            #1;
            check($sformatf("vec%0d_ready", v), 32'(req_ready), 1 << vecs[v].id);
            @(posedge clk); #1;
            req_valid = '0;
            #1;
            check($sformatf("vec%0d_early", v), 32'(res_valid), 0);
            @(posedge clk); #2;
            check($sformatf("vec%0d_valid", v), 32'(res_valid), 1);
            check($sformatf("vec%0d_id", v),    32'(res_id),    vecs[v].id);
            check($sformatf("vec%0d_re", v),    res_re,         vecs[v].e_re);
            check($sformatf("vec%0d_im", v),    res_im,         vecs[v].e_im);
        end

        // All requesters valid: grants rotate 0..3, results follow in the same order.
        reset_dut();
        load_rr_ops();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            req_valid = (c < 8) ? '1 : '0;
            #1;
            check($sformatf("rr%0d_ready", c), 32'(req_ready), (c < 8) ? (1 << (c % 4)) : 0);
            check_res($sformatf("rr%0d_res", c), (c >= 2) ? ((c - 2) % 4) : -1);
        end

        // Five-cycle result stall with traffic pending.
        reset_dut();
        for (int c = 0; c < 13; c++) begin
            @(posedge clk); #1;
            req_valid = (c < 10) ? '1 : '0;
            res_ready = (c >= 2 && c <= 6) ? 1'b0 : 1'b1;
            #1;
            g = st_rdy[c];
            check($sformatf("st%0d_ready", c), 32'(req_ready), (g < 0) ? 0 : (1 << g));
            check_res($sformatf("st%0d_res", c), st_res[c]);
        end

        // Only requesters 1 and 3; requester 3 withdraws before its turn.
        reset_dut();
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            req_valid = (c < 5) ? 4'b1010 : (c < 7) ? 4'b0010 : 4'b0000;
            #1;
            g = pr_g[c];
            check($sformatf("pr%0d_ready", c), 32'(req_ready), (g < 0) ? 0 : (1 << g));
            check_res($sformatf("pr%0d_res", c), (c >= 2) ? pr_g[c - 2] : -1);
        end

        // Reset with both stages occupied, then requester 0 wins first after release.
        reset_dut();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            req_valid = 4'b0100;
        end
        #1;
        check("mr_full_valid", 32'(res_valid), 1);
        check("mr_full_id",    32'(res_id),    2);
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        check("mr_rst_valid", 32'(res_valid), 0);
        check("mr_rst_id",    32'(res_id),    0);
        check("mr_rst_re",    res_re,         0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = '1;
        #1;
        check("mr_first_grant", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = '0;
        #1;
        check("mr_no_stale", 32'(res_valid), 0);
        @(posedge clk); #2;
        check_res("mr_res", 0);
        @(posedge clk); #2;
        check("mr_drain", 32'(res_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
